// File: rtl/pcler8_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pcler8_pkg
// Purpose  : Shared types and constants for the pcler8 interval timer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package pcler8_pkg;

    localparam int unsigned c_WIDTH = 8;

    localparam logic [c_WIDTH-1:0] c_TERMINAL = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pcler8_timer_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pcler8_timer_ctrl_if
// Purpose  : Configuration/control bus and status outputs of the timer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface pcler8_timer_ctrl_if
    import pcler8_pkg::*;
#(
    parameter int unsigned WIDTH = c_WIDTH
);
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_reload;
    logic             cfg_periodic;
    logic             start;
    logic             stop;
    logic             hold;
    logic             tick;
    logic             irq_ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc_pulse;
    logic             irq;
    logic             irq_ovf;

    modport master (
        output cfg_we, cfg_reload, cfg_periodic, start, stop, hold, tick, irq_ack,
        input  count, busy, tc_pulse, irq, irq_ovf
    );

    modport slave (
        input  cfg_we, cfg_reload, cfg_periodic, start, stop, hold, tick, irq_ack,
        output count, busy, tc_pulse, irq, irq_ovf
    );
endinterface
`default_nettype wire

// File: rtl/pcler8_count_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pcler8_count_cell
// Purpose  : Combinational next-count logic: load, increment, terminal reload.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module pcler8_count_cell
    import pcler8_pkg::*;
#(
    parameter int unsigned      WIDTH    = c_WIDTH,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  wire logic [WIDTH-1:0] i_count,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_en,
    input  wire logic             i_reload_tc,
    output logic      [WIDTH-1:0] o_count_nxt,
    output logic                  o_tc
);

    logic w_tc;

    assign w_tc = i_en && (i_count == TERMINAL);
    assign o_tc = w_tc;

    // An explicit load outranks everything; a terminal tick reloads instead of wrapping.
    always_comb begin
        o_count_nxt = i_count;
        if (i_load) begin
            o_count_nxt = i_load_val;
        end else if (w_tc && i_reload_tc) begin
            o_count_nxt = i_load_val;
        end else if (i_en) begin
            o_count_nxt = i_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcler8_timer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pcler8_timer_ctrl
// Purpose  : Interval timer controller: load/run/pause FSM, reload, sticky irq.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module pcler8_timer_ctrl
    import pcler8_pkg::*;
#(
    parameter int unsigned WIDTH = c_WIDTH
) (
    input wire logic          clk,
    input wire logic          rst,
    pcler8_timer_ctrl_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic             r_periodic;
    logic             r_tc_pulse;
    logic             r_irq;
    logic             r_irq_ovf;
    logic             w_load;
    logic             w_en;
    logic             w_tc;

    // stop beats start; start beats hold; hold beats tick
    assign w_load = bus.start && !bus.stop;
    assign w_en   = (r_state == ST_RUN) && !bus.stop && !bus.start && !bus.hold && bus.tick;

    pcler8_count_cell #(
        .WIDTH    (WIDTH),
        .TERMINAL (c_TERMINAL)
    ) u_cell (
        .i_count     (r_count),
        .i_load      (w_load),
        .i_load_val  (r_reload),
        .i_en        (w_en),
        .i_reload_tc (1'b1),
        .o_count_nxt (w_count_nxt),
        .o_tc        (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.stop)                    w_state_nxt = ST_IDLE;
                else if (bus.start)              w_state_nxt = ST_RUN;
                else if (bus.hold)               w_state_nxt = ST_PAUSE;
                else if (w_tc && !r_periodic)    w_state_nxt = ST_IDLE;
            end
            ST_PAUSE: begin
                if (bus.stop)                    w_state_nxt = ST_IDLE;
                else if (bus.start || !bus.hold) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_periodic <= 1'b0;
            r_tc_pulse <= 1'b0;
            r_irq      <= 1'b0;
            r_irq_ovf  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_tc_pulse <= w_tc;
            if (bus.cfg_we) begin
                r_reload   <= bus.cfg_reload;
                r_periodic <= bus.cfg_periodic;
            end
            // A terminal count coinciding with an ack re-arms irq but starts a fresh overflow window.
            if (w_tc) begin
                r_irq <= 1'b1;
                if (bus.irq_ack)  r_irq_ovf <= 1'b0;
                else if (r_irq)   r_irq_ovf <= 1'b1;
            end else if (bus.irq_ack) begin
                r_irq     <= 1'b0;
                r_irq_ovf <= 1'b0;
            end
        end
    end

    assign bus.count    = r_count;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.tc_pulse = r_tc_pulse;
    assign bus.irq      = r_irq;
    assign bus.irq_ovf  = r_irq_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pcler8_timer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_pcler8_timer_ctrl
// Purpose  : Directed self-checking bench for pcler8_timer_ctrl.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_pcler8_timer_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    pcler8_timer_ctrl_if #(.WIDTH(8)) bus ();

    pcler8_timer_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] rl, input logic per);
        bus.cfg_we       = 1'b1;
        bus.cfg_reload   = rl;
        bus.cfg_periodic = per;
        cyc();
        bus.cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.irq_ack = 1'b1;
        cyc();
        bus.irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++; if (bus.count !== 8'h00) $display("FAIL reset_count got=%h exp=00", bus.count); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
        n_checks++; if ({bus.tc_pulse, bus.irq, bus.irq_ovf} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {bus.tc_pulse, bus.irq, bus.irq_ovf}); else n_pass++;
        cyc();
        rst = 1'b0;
        cyc();
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); else n_pass++;
    endtask

    task automatic test_oneshot();
        set_cfg(8'hFC, 1'b0);
        n_checks++; if (bus.count !== 8'h00) $display("FAIL oneshot_cfg_noload got=%h exp=00", bus.count); else n_pass++;
        pulse_start();
        n_checks++; if (bus.count !== 8'hFC) $display("FAIL oneshot_load got=%h exp=FC", bus.count); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL oneshot_busy got=%b exp=1", bus.busy); else n_pass++;
        bus.tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] exp_c;
            exp_c = 8'hFD + 8'(i);
            cyc();
            n_checks++; if (bus.count !== exp_c) $display("FAIL oneshot_count[%0d] got=%h exp=%h", i, bus.count, exp_c); else n_pass++;
            n_checks++; if (bus.tc_pulse !== 1'b0) $display("FAIL oneshot_tc_early[%0d] got=%b exp=0", i, bus.tc_pulse); else n_pass++;
        end
        cyc();
        n_checks++; if (bus.count !== 8'hFC) $display("FAIL oneshot_reload got=%h exp=FC", bus.count); else n_pass++;
        n_checks++; if (bus.tc_pulse !== 1'b1) $display("FAIL oneshot_tc got=%b exp=1", bus.tc_pulse); else n_pass++;
        n_checks++; if (bus.irq !== 1'b1) $display("FAIL oneshot_irq got=%b exp=1", bus.irq); else n_pass++;
        n_checks++; if (bus.irq_ovf !== 1'b0) $display("FAIL oneshot_ovf got=%b exp=0", bus.irq_ovf); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL oneshot_idle got=%b exp=0", bus.busy); else n_pass++;
        cyc();
        n_checks++; if (bus.count !== 8'hFC) $display("FAIL idle_tick_ignored got=%h exp=FC", bus.count); else n_pass++;
        n_checks++; if (bus.tc_pulse !== 1'b0) $display("FAIL oneshot_tc_width got=%b exp=0", bus.tc_pulse); else n_pass++;
        bus.tick = 1'b0;
    endtask

    task automatic test_periodic();
        pulse_ack();
        n_checks++; if (bus.irq !== 1'b0) $display("FAIL periodic_preack got=%b exp=0", bus.irq); else n_pass++;
        set_cfg(8'hFE, 1'b1);
        pulse_start();
        n_checks++; if (bus.count !== 8'hFE) $display("FAIL periodic_load got=%h exp=FE", bus.count); else n_pass++;
        bus.tick = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            logic [7:0] exp_c;
            logic       exp_tc, exp_irq, exp_ovf;
            exp_c   = (i % 2 == 1) ? 8'hFF : 8'hFE;
            exp_tc  = (i % 2 == 0);
            exp_irq = (i >= 2);
            exp_ovf = (i >= 4);
            cyc();
            n_checks++; if (bus.count !== exp_c) $display("FAIL periodic_count[%0d] got=%h exp=%h", i, bus.count, exp_c); else n_pass++;
            n_checks++; if (bus.tc_pulse !== exp_tc) $display("FAIL periodic_tc[%0d] got=%b exp=%b", i, bus.tc_pulse, exp_tc); else n_pass++;
            n_checks++; if (bus.irq !== exp_irq) $display("FAIL periodic_irq[%0d] got=%b exp=%b", i, bus.irq, exp_irq); else n_pass++;
            n_checks++; if (bus.irq_ovf !== exp_ovf) $display("FAIL periodic_ovf[%0d] got=%b exp=%b", i, bus.irq_ovf, exp_ovf); else n_pass++;
        end
        bus.tick = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL periodic_busy got=%b exp=1", bus.busy); else n_pass++;
        pulse_ack();
        n_checks++; if ({bus.irq, bus.irq_ovf} !== 2'b00) $display("FAIL periodic_ack got=%b exp=00", {bus.irq, bus.irq_ovf}); else n_pass++;
    endtask

    task automatic test_hold();
        set_cfg(8'h10, 1'b1);
        pulse_start();
        bus.tick = 1'b1;
        cyc();
        cyc();
        n_checks++; if (bus.count !== 8'h12) $display("FAIL hold_pre got=%h exp=12", bus.count); else n_pass++;
        bus.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++; if (bus.count !== 8'h12) $display("FAIL hold_frozen[%0d] got=%h exp=12", i, bus.count); else n_pass++;
            n_checks++; if (bus.busy !== 1'b1) $display("FAIL hold_busy[%0d] got=%b exp=1", i, bus.busy); else n_pass++;
        end
        bus.hold = 1'b0;
        cyc();
        n_checks++; if (bus.count !== 8'h12) $display("FAIL hold_release got=%h exp=12", bus.count); else n_pass++;
        cyc();
        n_checks++; if (bus.count !== 8'h13) $display("FAIL hold_resume got=%h exp=13", bus.count); else n_pass++;
        bus.tick = 1'b0;
    endtask

    task automatic test_stop_start();
        set_cfg(8'h30, 1'b1);
        pulse_start();
        bus.tick = 1'b1;
        repeat (7) cyc();
        n_checks++; if (bus.count !== 8'h37) $display("FAIL restart_pre got=%h exp=37", bus.count); else n_pass++;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        n_checks++; if (bus.count !== 8'h30) $display("FAIL restart_load got=%h exp=30", bus.count); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL restart_busy got=%b exp=1", bus.busy); else n_pass++;
        cyc();
        cyc();
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        n_checks++; if (bus.count !== 8'h32) $display("FAIL stopstart_count got=%h exp=32", bus.count); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL stopstart_busy got=%b exp=0", bus.busy); else n_pass++;
        cyc();
        n_checks++; if (bus.count !== 8'h32) $display("FAIL stop_idle_count got=%h exp=32", bus.count); else n_pass++;
        bus.tick = 1'b0;
    endtask

    task automatic test_cfg_midrun();
        set_cfg(8'hF0, 1'b1);
        pulse_start();
        bus.tick = 1'b1;
        repeat (3) cyc();
        bus.cfg_we       = 1'b1;
        bus.cfg_reload   = 8'h80;
        bus.cfg_periodic = 1'b1;
        cyc();
        bus.cfg_we = 1'b0;
        n_checks++; if (bus.count !== 8'hF4) $display("FAIL cfg_midrun_undisturbed got=%h exp=F4", bus.count); else n_pass++;
        repeat (11) cyc();
        n_checks++; if (bus.count !== 8'hFF) $display("FAIL cfg_midrun_top got=%h exp=FF", bus.count); else n_pass++;
        cyc();
        n_checks++; if (bus.count !== 8'h80) $display("FAIL cfg_midrun_reload got=%h exp=80", bus.count); else n_pass++;
        n_checks++; if (bus.tc_pulse !== 1'b1) $display("FAIL cfg_midrun_tc got=%b exp=1", bus.tc_pulse); else n_pass++;
        bus.tick = 1'b0;
    endtask

    task automatic test_ack_coincide();
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        set_cfg(8'hFF, 1'b1);
        pulse_start();
        n_checks++; if ({bus.irq, bus.irq_ovf} !== 2'b10) $display("FAIL ackco_pre got=%b exp=10", {bus.irq, bus.irq_ovf}); else n_pass++;
        bus.tick    = 1'b1;
        bus.irq_ack = 1'b1;
        cyc();
        bus.irq_ack = 1'b0;
        n_checks++; if (bus.irq !== 1'b1) $display("FAIL ackco_irq got=%b exp=1", bus.irq); else n_pass++;
        n_checks++; if (bus.irq_ovf !== 1'b0) $display("FAIL ackco_ovf got=%b exp=0", bus.irq_ovf); else n_pass++;
        n_checks++; if (bus.tc_pulse !== 1'b1) $display("FAIL period1_tc got=%b exp=1", bus.tc_pulse); else n_pass++;
        n_checks++; if (bus.count !== 8'hFF) $display("FAIL period1_count got=%h exp=FF", bus.count); else n_pass++;
        cyc();
        n_checks++; if (bus.irq_ovf !== 1'b1) $display("FAIL period1_ovf got=%b exp=1", bus.irq_ovf); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.count !== 8'h00) $display("FAIL async_rst_count got=%h exp=00", bus.count); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL async_rst_busy got=%b exp=0", bus.busy); else n_pass++;
        n_checks++; if ({bus.tc_pulse, bus.irq, bus.irq_ovf} !== 3'b000) $display("FAIL async_rst_flags got=%b exp=000", {bus.tc_pulse, bus.irq, bus.irq_ovf}); else n_pass++;
        bus.tick = 1'b0;
        cyc();
        rst = 1'b0;
        pulse_start();
        n_checks++; if (bus.count !== 8'h00) $display("FAIL rst_reload_zero got=%h exp=00", bus.count); else n_pass++;
        bus.tick = 1'b1;
        repeat (255) cyc();
        n_checks++; if (bus.count !== 8'hFF) $display("FAIL period256_top got=%h exp=FF", bus.count); else n_pass++;
        n_checks++; if (bus.tc_pulse !== 1'b0) $display("FAIL period256_early_tc got=%b exp=0", bus.tc_pulse); else n_pass++;
        cyc();
        n_checks++; if (bus.count !== 8'h00) $display("FAIL period256_wrap got=%h exp=00", bus.count); else n_pass++;
        n_checks++; if (bus.tc_pulse !== 1'b1) $display("FAIL period256_tc got=%b exp=1", bus.tc_pulse); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_periodic_zero got=%b exp=0", bus.busy); else n_pass++;
        bus.tick = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_pass           = 0;
        rst              = 1'b1;
        bus.cfg_we       = 1'b0;
        bus.cfg_reload   = 8'h00;
        bus.cfg_periodic = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.hold         = 1'b0;
        bus.tick         = 1'b0;
        bus.irq_ack      = 1'b0;

        test_reset();
        test_oneshot();
        test_periodic();
        test_hold();
        test_stop_start();
        test_cfg_midrun();
        test_ack_coincide();
        test_reset_midrun();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
